// File: rtl/udcount4_seq_if.sv
// Button, setting and feedback bundle between the board side and udcount4_seq.
// master drives buttons/settings/feedback; slave is the sequencer.
interface udcount4_seq_if;
  logic       btn_run_n;
  logic       btn_step_n;
  logic       dir;
  logic [3:0] target;
  logic       stop_on_carry;
  logic [3:0] q;
  logic       carry;
  logic       ud;
  logic       enable;
  logic       busy;
  logic       done;
  logic [1:0] state;

  modport master (
    output btn_run_n, btn_step_n, dir, target, stop_on_carry, q, carry,
    input  ud, enable, busy, done, state
  );

  modport slave (
    input  btn_run_n, btn_step_n, dir, target, stop_on_carry, q, carry,
    output ud, enable, busy, done, state
  );
endinterface

// File: rtl/udcount4_seq.sv
// Sequencer for udcount4: two push buttons -> ud/enable (run, step, stop).
// Ports: clock, reset (async active-low), bus (udcount4_seq_if.slave).
module udcount4_seq #(
  parameter int DIV         = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic           clock,
  input logic           reset,
  udcount4_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam logic [7:0] LAST = 8'(DIV - 1);

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] run_s, step_s;
  logic                   run_old, step_old;
  logic                   run_edge, step_edge;
  logic [7:0]             presc, presc_n;
  logic                   enable, enable_n;
  logic                   chk, chk_n;
  logic                   ud, soc;
  logic [3:0]             tgt;
  logic                   enter, hit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_s    <= '1;
      step_s   <= '1;
      run_old  <= 1'b1;
      step_old <= 1'b1;
    end else begin
      run_s    <= {run_s[SYNC_STAGES-2:0], bus.btn_run_n};
      step_s   <= {step_s[SYNC_STAGES-2:0], bus.btn_step_n};
      run_old  <= run_s[SYNC_STAGES-1];
      step_old <= step_s[SYNC_STAGES-1];
    end
  end

  assign run_edge  = run_old & ~run_s[SYNC_STAGES-1];
  assign step_edge = step_old & ~step_s[SYNC_STAGES-1];

  // q/carry already reflect the last pulse when chk is high
  assign hit = (bus.q == tgt) | (soc & bus.carry);

  always_comb begin
    state_n  = state;
    enable_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (run_edge) begin
          state_n = RUN;
        end else if (step_edge) begin
          state_n  = STEP;
          enable_n = 1'b1;
        end
      end
      RUN: begin
        // pause beats a same-cycle match
        if (run_edge) begin
          state_n = IDLE;
        end else if (chk && hit) begin
          state_n = DONE;
        end else if (presc == LAST) begin
          enable_n = 1'b1;
        end
      end
      STEP: begin
        if (chk) begin
          state_n = hit ? DONE : IDLE;
        end
      end
      DONE: begin
        if (run_edge) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign enter = (state == IDLE) && (state_n != IDLE);

  // a check only survives if we stay in the same busy state
  assign chk_n = enable && (state_n == state);

  always_comb begin
    presc_n = '0;
    if (state == RUN && state_n == RUN) begin
      presc_n = (presc == LAST) ? '0 : presc + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      enable <= 1'b0;
      chk    <= 1'b0;
      presc  <= '0;
      ud     <= 1'b1;
      tgt    <= '0;
      soc    <= 1'b0;
    end else begin
      state  <= state_n;
      enable <= enable_n;
      chk    <= chk_n;
      presc  <= presc_n;
      if (enter) begin
        ud  <= bus.dir;
        tgt <= bus.target;
        soc <= bus.stop_on_carry;
      end
    end
  end

  assign bus.ud     = ud;
  assign bus.enable = enable;
  assign bus.busy   = (state == RUN) || (state == STEP);
  assign bus.done   = (state == DONE);
  assign bus.state  = state;

endmodule

// File: tb/tb_udcount4_seq.sv
// Bench for udcount4_seq with a behavioural udcount4 in the loop.
// Directed steps then random run/step operations against a lap model.
module tb_udcount4_seq;
  localparam int DIV = 4;
  localparam int SS  = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;

  udcount4_seq_if bus();

  udcount4_seq #(.DIV(DIV), .SYNC_STAGES(SS)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  logic [3:0] cq = 4'd0;
  logic       cc = 1'b0;
  logic       ld = 1'b0;
  logic [3:0] ld_val = 4'd0;
  int         cyc = 0;
  int         npulse = 0;
  int         pulse_t[1024];

  assign bus.q     = cq;
  assign bus.carry = cc;

  // udcount4 stand-in plus pulse logger
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (bus.enable) begin
      pulse_t[npulse % 1024] <= cyc;
      npulse <= npulse + 1;
    end
    if (ld) begin
      cq <= ld_val;
      cc <= 1'b0;
    end else if (bus.enable) begin
      if (bus.ud) begin
        cc <= (cq == 4'd15);
        cq <= cq + 4'd1;
      end else begin
        cc <= (cq == 4'd0);
        cq <= cq - 4'd1;
      end
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // pulses until stop, from plain modulo-16 arithmetic
  function automatic int ref_run(input int q0, input bit d, input int t,
                                 input bit s, output int qf);
    int qk;
    bit wrap;
    qf = q0;
    for (int k = 1; k <= 16; k++) begin
      qk   = d ? (q0 + k) % 16 : ((q0 - k) % 16 + 16) % 16;
      wrap = d ? (qk == 0) : (qk == 15);
      if (qk == t || (s && wrap)) begin
        qf = qk;
        return k;
      end
    end
    return 16;
  endfunction

  task automatic press(input bit r, input bit s);
    @(negedge clock);
    if (r) bus.btn_run_n = 1'b0;
    if (s) bus.btn_step_n = 1'b0;
    repeat (4) @(negedge clock);
    bus.btn_run_n  = 1'b1;
    bus.btn_step_n = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic preload(input int v);
    @(negedge clock);
    ld_val = 4'(v);
    ld = 1'b1;
    @(negedge clock);
    ld = 1'b0;
  endtask

  task automatic setup(input bit d, input int t, input bit s);
    bus.dir           = d;
    bus.target        = 4'(t);
    bus.stop_on_carry = s;
  endtask

  task automatic wait_done(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < DIV * 17 + 40; i++) begin
      @(negedge clock);
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({tag, " timeout"}, 32'd0, 32'd1);
  endtask

  function automatic int bad_gaps(input int a, input int b);
    int bad;
    bad = 0;
    for (int i = a + 1; i < b; i++)
      if (pulse_t[i % 1024] - pulse_t[(i - 1) % 1024] != DIV) bad++;
    return bad;
  endfunction

  task automatic do_run(input string tag, input int q0, input bit d,
                        input int t, input bit s);
    int p0, p1, expn, qf;
    preload(q0);
    setup(d, t, s);
    p0 = npulse;
    press(1'b1, 1'b0);
    bus.dir = ~d;
    wait_done(tag);
    expn = ref_run(q0, d, t, s, qf);
    check({tag, " pulses"}, npulse - p0, expn);
    check({tag, " q"}, cq, qf);
    check({tag, " state"}, bus.state, 2'b11);
    check({tag, " busy"}, bus.busy, 1'b0);
    check({tag, " ud"}, bus.ud, d);
    check({tag, " gaps"}, bad_gaps(p0, npulse), 0);
    p1 = npulse;
    repeat (10) @(negedge clock);
    check({tag, " no pulse in done"}, npulse - p1, 0);
    press(1'b1, 1'b0);
    check({tag, " ack"}, bus.state, 2'b00);
  endtask

  task automatic do_step(input string tag, input int q0, input bit d,
                         input int t, input bit s);
    int p0, qf, n;
    bit dn;
    preload(q0);
    setup(d, t, s);
    p0 = npulse;
    press(1'b0, 1'b1);
    repeat (4) @(negedge clock);
    n  = ref_run(q0, d, t, s, qf);
    dn = (n == 1);
    qf = d ? (q0 + 1) % 16 : (q0 + 15) % 16;
    check({tag, " pulses"}, npulse - p0, 1);
    check({tag, " q"}, cq, qf);
    check({tag, " state"}, bus.state, dn ? 2'b11 : 2'b00);
    check({tag, " done"}, bus.done, dn);
    if (dn) begin
      press(1'b1, 1'b0);
      check({tag, " ack"}, bus.state, 2'b00);
    end
  endtask

  initial begin
    int p0, p1;
    bit hit;
    bus.btn_run_n  = 1'b1;
    bus.btn_step_n = 1'b1;
    setup(1'b1, 0, 1'b0);

    repeat (3) @(negedge clock);
    check("rst state", bus.state, 2'b00);
    check("rst enable", bus.enable, 1'b0);
    check("rst ud", bus.ud, 1'b1);
    check("rst busy", bus.busy, 1'b0);
    check("rst done", bus.done, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    do_step("step t9", 3, 1'b1, 9, 1'b0);
    do_step("step t4", 3, 1'b1, 4, 1'b0);
    do_run("run up7", 0, 1'b1, 7, 1'b0);
    do_run("run soc", 2, 1'b0, 9, 1'b1);
    do_run("run nosoc", 2, 1'b0, 9, 1'b0);

    // pause after five pulses
    preload(0);
    setup(1'b1, 12, 1'b0);
    p0 = npulse;
    press(1'b1, 1'b0);
    bus.dir = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (npulse - p0 >= 5) begin
        hit = 1'b1;
        break;
      end
    end
    check("pause reached", hit, 1'b1);
    check("pause ud held", bus.ud, 1'b1);
    bus.btn_run_n = 1'b0;
    repeat (4) @(negedge clock);
    bus.btn_run_n = 1'b1;
    repeat (20) @(negedge clock);
    check("pause state", bus.state, 2'b00);
    check("pause q", cq, 4'd5);
    check("pause pulses", npulse - p0, 5);

    // both buttons together, then steps ignored in RUN and DONE
    preload(0);
    setup(1'b1, 15, 1'b0);
    p0 = npulse;
    press(1'b1, 1'b1);
    check("both state", bus.state, 2'b01);
    press(1'b0, 1'b1);
    check("step in run", bus.state, 2'b01);
    wait_done("both");
    check("both pulses", npulse - p0, 15);
    check("both gaps", bad_gaps(p0, npulse), 0);
    check("both q", cq, 4'd15);
    p1 = npulse;
    press(1'b0, 1'b1);
    check("step in done", bus.state, 2'b11);
    check("step in done pulses", npulse - p1, 0);
    press(1'b1, 1'b0);
    check("both ack", bus.state, 2'b00);

    // reset in the middle of a run
    preload(5);
    setup(1'b0, 6, 1'b0);
    press(1'b1, 1'b0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    check("mid rst state", bus.state, 2'b00);
    check("mid rst enable", bus.enable, 1'b0);
    check("mid rst ud", bus.ud, 1'b1);
    check("mid rst busy", bus.busy, 1'b0);
    check("mid rst done", bus.done, 1'b0);
    p1 = npulse;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (12) @(negedge clock);
    check("after rst pulses", npulse - p1, 0);
    check("after rst state", bus.state, 2'b00);

    for (int i = 0; i < 8; i++) begin
      int q0, t;
      bit d, s;
      q0 = int'($urandom_range(0, 15));
      t  = int'($urandom_range(0, 15));
      d  = 1'($urandom_range(0, 1));
      s  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1)
        do_run($sformatf("rnd run %0d", i), q0, d, t, s);
      else
        do_step($sformatf("rnd step %0d", i), q0, d, t, s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
